tqv_periph_bus_master: RTL
==========================

Name: tqv_periph_bus_master

Overview:
Initiator for the TinyQV peripheral register interface. It drives address, write data and the read/write size strobes into a peripheral such as the PRISM block, and waits for data_ready on reads.
Commands arrive through a small command FIFO with a valid/ready handshake. Each command produces exactly one response through a second valid/ready handshake.
Used to sequence peripheral configuration (e.g. loading PRISM state tables) without the CPU, and as a bus-functional driver for peripheral verification.

Parameters:
CMD_DEPTH, 2, command FIFO entries; power of two, minimum 2.
TIMEOUT, 15, maximum cycles a read waits for data_ready before error; range 1..255.

Ports:
clk  in  1  clock.
rst  in  1  reset; reset is asynchronous and active-high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO not full.
cmd_write  in  1  1 = write, 0 = read.
cmd_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
cmd_addr  in  6  peripheral register address.
cmd_wdata  in  32  write data.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed.
rsp_rdata  out  32  read data, zero-extended by size; 0 for writes and errors.
rsp_err  out  1  timeout or illegal size.
address  out  6  to peripheral.
data_in  out  32  to peripheral.
data_write_n  out  2  11 idle, else the size code.
data_read_n  out  2  11 idle, else the size code.
data_out  in  32  from peripheral.
data_ready  in  1  from peripheral.
user_interrupt  in  1  peripheral interrupt line.
irq_clear  in  1  clears irq_pending.
irq_pending  out  1  sticky rising-edge capture of user_interrupt.

Behaviour:
- Reset values: data_write_n = data_read_n = 11; address = 0; data_in = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; irq_pending = 0; FIFO empty; FSM in IDLE.
- Reset asserted mid-transaction: bus strobes go to 11 immediately, the in-flight command is discarded with no response, and the FIFO is flushed.
- All bus outputs are registered.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full; it is combinational from the FIFO count.
  - A push and a pop in the same cycle are both honoured when the FIFO is full.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - FIFO non-empty: pop one entry.
  - Illegal size: go to RESP with rsp_err = 1 and no bus activity.
  - Write: go to WRITE; address, data_in and data_write_n = size are driven the next cycle.
  - Read: go to READ; address and data_read_n = size are driven the next cycle, and the timeout counter is cleared.
- WRITE: strobe is held for exactly one cycle and data_ready is ignored. Then data_write_n = 11, rsp_err = 0, rsp_rdata = 0, go to RESP.
- READ:
  - data_read_n is held at the size code and address is stable.
  - In any cycle with data_ready = 1, capture data_out masked to the size (byte [7:0], half [15:0], word [31:0]), drop the strobe, and go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT with data_ready still 0: rsp_err = 1, rsp_rdata = 0, strobe dropped, go to RESP.
  - data_ready sampled in the cycle the counter reaches TIMEOUT still completes the read normally; ready wins over timeout.
- RESP: rsp_valid = 1 with stable rsp_rdata and rsp_err until rsp_ready; then go to IDLE. rsp_valid is low in IDLE.
- Latency and throughput:
  - Read with data_ready tied 1: pop at cycle 0, strobe at cycle 1, rsp_valid at cycle 2.
  - Back-to-back writes with rsp_ready = 1: one command per 3 cycles.
- Between transactions, address and data_in hold their last driven values; only the strobes return to 11.
- Interrupt capture:
  - Register user_interrupt once; irq_pending is set on a 0→1 transition.
  - irq_clear clears irq_pending.
  - Set and clear in the same cycle: set wins.

Decomposition:
- Shared package tqv_bus_pkg holds:
  - size codes SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_IDLE = 2'b11;
  - FSM state enum;
  - the packed command struct {write, size, addr, wdata}.
- One sub-module, tqv_cmd_fifo: parameterised synchronous FIFO of the command struct, with full/empty flags.

Test Plan:
- Write: cmd {write = 1, size = 10, addr = 6'h28, wdata = 32'hF000_0010} → one cycle with data_write_n = 10, address = 6'h28, data_in = 32'hF000_0010; then rsp_valid with rsp_err = 0 and rsp_rdata = 0.
- Byte read: cmd {read, size = 00, addr = 6'h18}; peripheral returns data_out = 32'h0000_03A5 with data_ready = 1 → data_read_n = 00 for 1 cycle; rsp_rdata = 32'h0000_00A5, rsp_err = 0.
- Timeout: word read, data_ready held 0, TIMEOUT = 15 → strobe active exactly 15 cycles, then rsp_err = 1, rsp_rdata = 0. Repeat with data_ready = 1 on the 15th cycle → rsp_err = 0 and data captured.
- Backpressure: push 3 commands with CMD_DEPTH = 2 while rsp_ready = 0 → cmd_ready drops after the FIFO fills; rsp_valid and rsp data stay stable until rsp_ready; all 3 responses are delivered in order.
- Illegal size: cmd size = 11 → no strobe ever leaves 11; rsp_err = 1.
- Reset and interrupt: assert rst during READ → strobes 11 in the same cycle, no response, FIFO empty. Pulse user_interrupt 0→1 with irq_clear high in the same cycle → irq_pending = 1; a later irq_clear → irq_pending = 0.

Source files
------------

// File: rtl/tqv_bus_pkg.sv
// Shared definitions for the TinyQV peripheral bus master.
//   - Size codes used on cmd_size, data_write_n and data_read_n.
//   - Bus-master FSM state type.
//   - Packed command record stored in the command FIFO.
//   - size_mask(): zero-extends peripheral read data to the access size.
package tqv_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_IDLE = 2'b11;  // strobe inactive / illegal size

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {24'd0, data[7:0]};
            SZ_HALF: return {16'd0, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/tqv_cmd_fifo.sv
// Synchronous FIFO of bus-master commands.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (flushes the FIFO)
//   push, push_data  write one command when push is high
//   pop              remove the head entry when pop is high
//   pop_data         head entry (valid while !empty)
//   full, empty      occupancy flags
// A push while full is still honoured when a pop happens in the same cycle.
module tqv_cmd_fifo
    import tqv_bus_pkg::*;
#(
    parameter int DEPTH = 2  // power of two, minimum 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // DEPTH is a power of two, so the count MSB alone marks "full".
    assign full     = count[AW];
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count need one, and leaving
    // the array out of the reset keeps it mappable onto plain RAM/flops without reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tqv_periph_bus_master.sv
// Initiator for the TinyQV peripheral register interface.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake into the command FIFO
//   cmd_write/size/addr/wdata      command fields (size 11 is illegal)
//   rsp_valid/rsp_ready            response handshake, one response per command
//   rsp_rdata, rsp_err             read data (zero-extended) and error flag
//   address, data_in               registered bus address / write data
//   data_write_n, data_read_n      registered strobes: 11 idle, else size code
//   data_out, data_ready           read data and completion from the peripheral
//   user_interrupt                 peripheral interrupt line
//   irq_clear, irq_pending         sticky rising-edge capture of user_interrupt
module tqv_periph_bus_master
    import tqv_bus_pkg::*;
#(
    parameter int CMD_DEPTH = 2,  // power of two, minimum 2
    parameter int TIMEOUT   = 15  // 1..255 cycles of read strobe before error
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready,
    input  logic        user_interrupt,
    input  logic        irq_clear,
    output logic        irq_pending
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    cmd_t       cmd_in;
    cmd_t       cmd_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    state_t     state;
    logic [7:0] wait_cnt;
    logic       int_q;

    assign cmd_in    = '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign pop       = (state == ST_IDLE) && !fifo_empty;

    tqv_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data (cmd_in),
        .pop       (pop),
        .pop_data  (cmd_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: all state and outputs here are assigned with <= so every branch
    // sees the pre-edge values and the block maps directly onto flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            address      <= '0;
            data_in      <= '0;
            data_write_n <= SZ_IDLE;
            data_read_n  <= SZ_IDLE;
            wait_cnt     <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (cmd_head.size == SZ_IDLE) begin
                            // Illegal size: answer with an error, bus untouched.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= ST_RESP;
                        end else if (cmd_head.write) begin
                            address      <= cmd_head.addr;
                            data_in      <= cmd_head.wdata;
                            data_write_n <= cmd_head.size;
                            state        <= ST_WRITE;
                        end else begin
                            address     <= cmd_head.addr;
                            data_read_n <= cmd_head.size;
                            wait_cnt    <= '0;
                            state       <= ST_READ;
                        end
                    end
                end

                ST_WRITE: begin
                    // Single-cycle write strobe; data_ready is not consulted.
                    data_write_n <= SZ_IDLE;
                    rsp_valid    <= 1'b1;
                    rsp_err      <= 1'b0;
                    rsp_rdata    <= '0;
                    state        <= ST_RESP;
                end

                ST_READ: begin
                    // The read strobe itself carries the access size.
                    if (data_ready) begin
                        rsp_rdata   <= size_mask(data_read_n, data_out);
                        rsp_err     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        data_read_n <= SZ_IDLE;
                        state       <= ST_RESP;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        // Counter would reach TIMEOUT this cycle: give up.
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_valid   <= 1'b1;
                        data_read_n <= SZ_IDLE;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Interrupt capture: a new rising edge takes priority over irq_clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_q       <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            int_q <= user_interrupt;
            if (user_interrupt && !int_q) begin
                irq_pending <= 1'b1;
            end else if (irq_clear) begin
                irq_pending <= 1'b0;
            end
        end
    end

endmodule
